// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    // Access sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // Identifies which requester owns the current access.
    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_e;

    localparam int unsigned DefaultDepth = 1024;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the port not granted last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic   req_fetch_i,
    input  logic   req_data_i,
    input  owner_e last_owner_i,
    output owner_e winner_o
);

    // Pick the winner. When there is no request the result is unused.
    always_comb begin
        winner_o = OWN_I;
        if (req_fetch_i && req_data_i) begin
            winner_o = (last_owner_i == OWN_D) ? OWN_I : OWN_D;
        end else if (req_data_i) begin
            winner_o = OWN_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one memory.
// Each access takes ACCESS (grant, memory strobe) then RESP (rvalid).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = DefaultDepth
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_writemem,
    output logic              mem_readmem,
    input  logic [DATA_W-1:0] mem_readmem_out
);

    // One extra bit so DEPTH is representable even when it equals 2**ADDR_W.
    localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    owner_e            winner;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              in_range;

    rr_arb2 u_rr_arb2 (
        .req_fetch_i  (i_req),
        .req_data_i   (d_req),
        .last_owner_i (last_owner_q),
        .winner_o     (winner)
    );

    assign in_range = ({1'b0, addr_q} < DepthW);

    // Next-state: accept a request from IDLE/RESP, capture read data in ACCESS.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE, RESP: begin
                if (i_req || d_req) begin
                    state_d      = ACCESS;
                    owner_d      = winner;
                    last_owner_d = winner;
                    if (winner == OWN_I) begin
                        // Fetch port is read-only.
                        addr_d  = i_addr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end else begin
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                        we_d    = d_we;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = (in_range && !we_q) ? mem_readmem_out : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: grant and memory strobes in ACCESS, response in RESP.
    always_comb begin
        i_gnt         = 1'b0;
        d_gnt         = 1'b0;
        i_rvalid      = 1'b0;
        d_rvalid      = 1'b0;
        i_err         = 1'b0;
        d_err         = 1'b0;
        i_rdata       = '0;
        d_rdata       = '0;
        mem_address   = '0;
        mem_writedata = '0;
        mem_writemem  = 1'b0;
        mem_readmem   = 1'b0;
        if (state_q == ACCESS) begin
            i_gnt         = (owner_q == OWN_I);
            d_gnt         = (owner_q == OWN_D);
            mem_address   = addr_q;
            mem_writedata = wdata_q;
            mem_writemem  = in_range && we_q;
            mem_readmem   = in_range && !we_q;
        end else if (state_q == RESP) begin
            if (owner_q == OWN_I) begin
                i_rvalid = 1'b1;
                i_err    = !in_range;
                i_rdata  = rdata_q;
            end else begin
                d_rvalid = 1'b1;
                d_err    = !in_range;
                d_rdata  = rdata_q;
            end
        end
    end

    // State registers; async reset clears state so every output drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            we_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            we_q         <= we_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard and memory model.
module tb_mem_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;

    typedef struct {
        logic          port;   // 0 = fetch, 1 = data
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid, d_err;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_writedata;
    logic          mem_writemem, mem_readmem;
    logic [DW-1:0] mem_readmem_out;

    logic [DW-1:0] mem [DEPTH];
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    int unsigned   wr_count = 0;
    int unsigned   wr0;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    mem_arbiter #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_req           (i_req),
        .i_addr          (i_addr),
        .i_gnt           (i_gnt),
        .i_rvalid        (i_rvalid),
        .i_err           (i_err),
        .i_rdata         (i_rdata),
        .d_req           (d_req),
        .d_we            (d_we),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_gnt           (d_gnt),
        .d_rvalid        (d_rvalid),
        .d_err           (d_err),
        .d_rdata         (d_rdata),
        .mem_address     (mem_address),
        .mem_writedata   (mem_writedata),
        .mem_writemem    (mem_writemem),
        .mem_readmem     (mem_readmem),
        .mem_readmem_out (mem_readmem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on rising edge, preload port.
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr[9:0]] <= pre_data;
        end else if (mem_writemem && mem_address < DEPTH) begin
            mem[mem_address[9:0]] <= mem_writedata;
        end
        if (mem_writemem) wr_count <= wr_count + 1;
    end
    assign mem_readmem_out = (mem_address < DEPTH) ? mem[mem_address[9:0]] : '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_resp();
        exp_t e;
        if (i_rvalid === 1'b1 || d_rvalid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_empty_at_rvalid", 64'(sb.size()), 64'd1);
            end else begin
                e = sb.pop_front();
                if (e.port == 1'b0) begin
                    check("i_rvalid", 64'(i_rvalid), 64'd1);
                    check("i_rdata", 64'(i_rdata), 64'(e.rdata));
                    check("i_err", 64'(i_err), 64'(e.err));
                    check("d_quiet", {d_rvalid, d_err, d_rdata}, 64'd0);
                end else begin
                    check("d_rvalid", 64'(d_rvalid), 64'd1);
                    check("d_rdata", 64'(d_rdata), 64'(e.rdata));
                    check("d_err", 64'(d_err), 64'(e.err));
                    check("i_quiet", {i_rvalid, i_err, i_rdata}, 64'd0);
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_resp();
    endtask

    task automatic push(input logic port, input logic [DW-1:0] rdata, input logic err);
        exp_t e;
        e.port  = port;
        e.rdata = rdata;
        e.err   = err;
        sb.push_back(e);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        pre_en   = 1'b1;
        pre_addr = a;
        pre_data = v;
        @(posedge clk);
        #1;
        pre_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_flags"}, {i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err,
                                mem_writemem, mem_readmem}, 64'd0);
        check({tag, "_rdata"}, {i_rdata, d_rdata}, 64'd0);
        check({tag, "_mem"}, {mem_address, mem_writedata}, 64'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        pre_en  = 1'b0;
        pre_addr = '0;
        pre_data = '0;

        preload(32'd8, 32'd4);
        preload(32'd4, 32'hFFFF_FFFE);
        preload(32'd0, 32'h0BAD_F00D);
        preload(32'd5, 32'd0);
        check_all_zero("reset");
        rst_n = 1'b1;

        // Single fetch read of word 8.
        i_req  = 1'b1;
        i_addr = 32'd8;
        push(1'b0, 32'd4, 1'b0);
        tick();
        check("fetch_gnt", {i_gnt, d_gnt, mem_readmem, mem_writemem}, 64'b1010);
        check("fetch_addr", 64'(mem_address), 64'd8);
        i_req = 1'b0;
        tick();
        check("fetch_rvalid", 64'(i_rvalid), 64'd1);
        tick();
        check("fetch_idle", {i_gnt, i_rvalid}, 64'd0);

        // Data write then back-to-back read of word 5.
        wr0     = wr_count;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'd5;
        d_wdata = 32'hDEAD_BEEF;
        push(1'b1, 32'd0, 1'b0);
        tick();
        check("wr_gnt", {i_gnt, d_gnt, mem_writemem, mem_readmem}, 64'b0110);
        check("wr_bus", {mem_address, mem_writedata}, {32'd5, 32'hDEAD_BEEF});
        d_req = 1'b0;
        tick();
        check("wr_rvalid", 64'(d_rvalid), 64'd1);
        d_req = 1'b1;
        d_we  = 1'b0;
        push(1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("rd_gnt", {d_gnt, mem_readmem, mem_writemem}, 64'b110);
        d_req = 1'b0;
        tick();
        check("rd_rvalid", 64'(d_rvalid), 64'd1);
        check("wr_once", 64'(wr_count - wr0), 64'd1);
        tick();

        // Continuous tie: I, D, I, D.
        i_req  = 1'b1;
        i_addr = 32'd8;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'd4;
        push(1'b0, 32'd4, 1'b0);
        push(1'b1, 32'hFFFF_FFFE, 1'b0);
        push(1'b0, 32'd4, 1'b0);
        push(1'b1, 32'hFFFF_FFFE, 1'b0);
        tick();
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tie_gnt%0d", k), {i_gnt, d_gnt},
                  (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k == 3) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
            tick();
            check($sformatf("tie_rvalid%0d", k), {i_rvalid, d_rvalid},
                  (k % 2 == 0) ? 64'b10 : 64'b01);
            if (k < 3) tick();
        end
        tick();
        check("tie_sb_drained", 64'(sb.size()), 64'd0);

        // Out-of-range write.
        wr0     = wr_count;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'd1024;
        d_wdata = 32'h1234_5678;
        push(1'b1, 32'd0, 1'b1);
        tick();
        check("oor_gnt", {d_gnt, mem_writemem, mem_readmem}, 64'b100);
        d_req = 1'b0;
        tick();
        check("oor_rvalid", {d_rvalid, d_err}, 64'b11);
        check("oor_no_write", 64'(wr_count - wr0), 64'd0);
        check("oor_word0", 64'(mem[0]), 64'h0BAD_F00D);
        tick();

        // Reset during the ACCESS of a write to word 4.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'd4;
        d_wdata = 32'h1111_1111;
        tick();
        check("rst_pre_write", 64'(mem_writemem), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("rst_word4", 64'(mem[4]), 64'hFFFF_FFFE);
        rst_n  = 1'b1;
        i_req  = 1'b1;
        i_addr = 32'd8;
        d_req  = 1'b1;
        d_addr = 32'd4;
        push(1'b0, 32'd4, 1'b0);
        tick();
        check("rst_tie_gnt", {i_gnt, d_gnt}, 64'b10);
        i_req = 1'b0;
        d_req = 1'b0;
        tick();
        check("rst_tie_rvalid", 64'(i_rvalid), 64'd1);
        tick();

        // Fetch read of word 4; the data port stays silent.
        i_req  = 1'b1;
        i_addr = 32'd4;
        push(1'b0, 32'hFFFF_FFFE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            i_req = 1'b0;
            check($sformatf("f4_d_rvalid%0d", k), 64'(d_rvalid), 64'd0);
            check($sformatf("f4_i_rvalid%0d", k), 64'(i_rvalid), (k == 1) ? 64'd1 : 64'd0);
        end

        check("final_sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the word width.
REQ-002 SHALL have parameter ADDR_W, default 32, the address width.
REQ-003 SHALL have parameter DEPTH, default 1024, the number of words; addresses 0..DEPTH-1 are valid.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports i_req input 1 and i_addr input ADDR_W: the instruction-fetch read request and its word address.
REQ-007 SHALL have ports i_gnt, i_rvalid and i_err, each output 1, and i_rdata output DATA_W: the fetch accept, response, error and data signals.
REQ-008 SHALL have ports d_req input 1, d_we input 1, d_addr input ADDR_W and d_wdata input DATA_W: the data-port request, write enable, address and write data.
REQ-009 SHALL have ports d_gnt, d_rvalid and d_err, each output 1, and d_rdata output DATA_W: the data-port accept, response, error and data signals.
REQ-010 SHALL have memory-side ports mem_address output ADDR_W, mem_writedata output DATA_W, mem_writemem output 1, mem_readmem output 1 and mem_readmem_out input DATA_W; memory reads are combinational and writes occur on the rising clock edge.

Function
REQ-011 SHALL implement a state machine with states IDLE, ACCESS and RESP.
REQ-012 SHALL, in IDLE or RESP with any request high, latch the owner, address, write data and write enable at the clock edge and go to ACCESS; with no request, go to (or stay in) IDLE.
REQ-013 SHALL go from ACCESS to RESP unconditionally.
REQ-014 SHALL hold the owner's gnt high for exactly the ACCESS cycle (Moore output).
REQ-015 SHALL require each requester to hold req and payload stable until it sees gnt, and to drop req at the next edge unless it is issuing a new request.
REQ-016 SHALL drive the mem_* outputs from latched registers only in ACCESS; outside ACCESS all mem_* outputs are 0.
REQ-017 SHALL, in ACCESS for a valid read, set mem_readmem=1 and capture mem_readmem_out into the rdata register at the end of the cycle.
REQ-018 SHALL, in ACCESS for a valid write, set mem_writemem=1 and mem_writedata to the latched data; rdata for a write response is 0.
REQ-019 SHALL treat the fetch port as read-only; d_we applies to the data port only.
REQ-020 SHALL pulse the owner's rvalid for exactly the RESP cycle with rdata valid; the non-owner's outputs stay 0.
REQ-021 SHALL give the timing: req seen in cycle N (IDLE) -> gnt in N+1 -> rvalid in N+2; back-to-back accesses start every 2 cycles.
REQ-022 SHALL arbitrate round-robin: when both requests are high, grant the port not granted last; a single request is granted regardless.
REQ-023 SHALL update last_owner on every accepted request; it resets to D, so I wins the first tie.
REQ-024 SHALL treat a latched address >= DEPTH as out of range: no mem_readmem or mem_writemem in ACCESS, err=1 with rvalid in RESP, rdata=0.
REQ-025 SHALL ignore a request that arrives during ACCESS until the following RESP or IDLE cycle.

Reset
REQ-026 SHALL, on rst_n low at any time, immediately force state IDLE, last_owner D, the latched registers 0, and all outputs (gnt, rvalid, err, rdata, mem_*) to 0.
REQ-027 SHALL guarantee that reset asserted during ACCESS drops mem_writemem combinationally, so no write is committed.
REQ-028 SHALL evaluate no request in the cycle rst_n deasserts before the first rising edge; arbitration starts at the first edge with rst_n high.

Structure
REQ-029 SHALL define, in a shared package mem_arb_pkg: the state enum (IDLE, ACCESS, RESP), the owner enum (OWN_I, OWN_D) and the default DEPTH constant.
REQ-030 SHALL place the 2-way round-robin picker (inputs: two requests and last_owner; output: winner) in sub-module rr_arb2; all other logic stays in mem_arbiter.

Verification
REQ-031 SHALL cover a single fetch read: memory word 8 = 4, i_req with i_addr=8 at cycle 0 -> i_gnt at cycle 1, i_rvalid=1 with i_rdata=4 at cycle 2, i_err=0.
REQ-032 SHALL cover a data write then read: write 0xDEADBEEF to address 5, then read address 5 -> d_rdata=0xDEADBEEF; mem_writemem high exactly one cycle.
REQ-033 SHALL cover a continuous tie: i_req and d_req both held high for 4 accesses -> grant order I, D, I, D; each rvalid 2 cycles after its request is accepted.
REQ-034 SHALL cover out of range: d write to address 1024 -> d_err=1 and d_rvalid=1 in RESP, mem_writemem never asserted, memory contents unchanged.
REQ-035 SHALL cover reset mid-access: rst_n low during the ACCESS of a write to address 4 -> mem_writemem drops at once, word 4 keeps its old value, all outputs 0; after release the next tie is granted to I.
REQ-036 SHALL cover a fetch read of address 4 holding 0xFFFFFFFE -> i_rdata=0xFFFFFFFE with d_rvalid staying 0 throughout.
